vc_output_arbiter: RTL

Output-port arbiter and buffer for one ring-router output channel (cw, ccw or pe). Two input requesters compete for the port. Each of the two virtual channels (odd/even, selected by the router's alternating `polarity`) has its own one-entry output buffer and its own least-recently-granted pointer. The block grants, captures the winning 64-bit packet (with optional hop decrement) and drives the downstream send/ready handshake phase by phase. The router instantiates it three times, once per output.

---
 rtl/ring_router_pkg.sv | 26 ++
 rtl/lru_pick2.sv | 41 ++++
 rtl/vc_output_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/ring_router_pkg.sv
// Shared ring-router definitions: packet geometry, VC indices, packet layout,
// per-VC buffer states and the hop-field helper used by the output arbiters.
package ring_router_pkg;

  localparam int RR_DATA_W  = 64;
  localparam int RR_HOP_MSB = 55;
  localparam int RR_HOP_LSB = 48;

  localparam logic VC_ODD  = 1'b0;
  localparam logic VC_EVEN = 1'b1;

  // Packet layout: hop count sits in bits [55:48]
  typedef struct packed {
    logic [3:0]  vc;
    logic [3:0]  dir;
    logic [7:0]  hop;
    logic [47:0] payload;
  } packet_t;

  // Occupancy of one VC output buffer
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } vc_state_e;

endpackage

// File: rtl/lru_pick2.sv
// Two-requester least-recently-granted picker. One priority bit names the
// favoured requester; it flips to the loser whenever a grant is issued.
module lru_pick2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic pri_q;
  logic pri_d;

  // Pick a winner when enabled; a tie goes to the favoured requester
  always_comb begin
    grant = 2'b00;
    pri_d = pri_q;
    if (en) begin
      if (req[0] && (!req[1] || !pri_q)) begin
        grant = 2'b01;
      end else if (req[1]) begin
        grant = 2'b10;
      end
    end
    if (grant[0]) begin
      pri_d = 1'b1;
    end else if (grant[1]) begin
      pri_d = 1'b0;
    end
  end

  // Priority bit register; requester 0 favoured out of reset
  always_ff @(posedge clk) begin
    if (reset) begin
      pri_q <= 1'b0;
    end else begin
      pri_q <= pri_d;
    end
  end

endmodule

// File: rtl/vc_output_arbiter.sv
// Output-port arbiter for one ring-router channel. Two VCs (odd/even, chosen
// by the alternating polarity input) each own a one-entry buffer and an LRU
// picker. Build option: define VC_ARB_HOP_DEC_EN to decrement the hop field
// of every captured packet (wrapping 0x00 -> 0xFF).
module vc_output_arbiter
  import ring_router_pkg::*;
#(
  parameter int DATA_W  = RR_DATA_W,
  parameter int HOP_MSB = RR_HOP_MSB,
  parameter int HOP_LSB = RR_HOP_LSB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              polarity,
  input  logic [1:0]        req,
  input  logic [DATA_W-1:0] din0,
  input  logic [DATA_W-1:0] din1,
  output logic [1:0]        grant,
  output logic              so,
  input  logic              ro,
  output logic [DATA_W-1:0] dout,
  output logic [1:0]        full
);

  localparam int HOP_W = HOP_MSB - HOP_LSB + 1;
`ifdef VC_ARB_HOP_DEC_EN
  localparam bit HOP_DEC_EN = 1'b1;
`else
  localparam bit HOP_DEC_EN = 1'b0;
`endif

  vc_state_e         state_q [2];
  vc_state_e         state_d [2];
  logic [DATA_W-1:0] pkt_q   [2];
  logic [DATA_W-1:0] pkt_d   [2];
  logic [1:0][1:0]   vc_grant;
  logic [DATA_W-1:0] sel_pkt;
  logic [DATA_W-1:0] cap_pkt;

  // Only the VC matching polarity can grant, so the OR is one-hot or zero
  assign grant = vc_grant[0] | vc_grant[1];

  // Select the winning packet and optionally decrement its hop field
  always_comb begin
    sel_pkt = grant[1] ? din1 : din0;
    cap_pkt = sel_pkt;
    if (HOP_DEC_EN) begin
      cap_pkt[HOP_MSB:HOP_LSB] = sel_pkt[HOP_MSB:HOP_LSB] - {{(HOP_W-1){1'b0}}, 1'b1};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_vc
      localparam logic VC_ID = 1'(gi);
      logic active;
      logic pick_en;

      assign active  = (polarity == VC_ID);
      assign pick_en = active && (state_q[gi] == ST_EMPTY);

      lru_pick2 u_pick (
        .clk   (clk),
        .reset (reset),
        .en    (pick_en),
        .req   (req),
        .grant (vc_grant[gi])
      );

      // Fill on grant while empty, drain on ro while full; both need this VC's phase
      always_comb begin
        state_d[gi] = state_q[gi];
        pkt_d[gi]   = pkt_q[gi];
        if (pick_en && (vc_grant[gi] != 2'b00)) begin
          state_d[gi] = ST_FULL;
          pkt_d[gi]   = cap_pkt;
        end else if (active && ro && (state_q[gi] == ST_FULL)) begin
          state_d[gi] = ST_EMPTY;
        end
      end

      // Buffer and occupancy registers; reset discards any held packet
      always_ff @(posedge clk) begin
        if (reset) begin
          state_q[gi] <= ST_EMPTY;
          pkt_q[gi]   <= '0;
        end else begin
          state_q[gi] <= state_d[gi];
          pkt_q[gi]   <= pkt_d[gi];
        end
      end

      assign full[gi] = (state_q[gi] == ST_FULL);
    end
  endgenerate

  // Downstream view follows the current phase
  assign so   = full[polarity];
  assign dout = pkt_q[polarity];

endmodule
